ram_bist_ctrl: RTL and testbench
================================

RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

Interface
REQ-001 SHALL have parameter AW, default 2: RAM address width; depth is 2^AW words.
REQ-002 SHALL have parameter DW, default 3: RAM data width.
REQ-003 SHALL have port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port START, input, 1: test request, sampled in IDLE only.
REQ-006 SHALL have port A, output, AW: RAM address, registered.
REQ-007 SHALL have port D, output, DW: RAM write data, registered.
REQ-008 SHALL have port EN, output, 1: RAM access enable, registered.
REQ-009 SHALL have port WR, output, 1: 1 = write, 0 = read, registered.
REQ-010 SHALL have port Q, input, DW: RAM read data, valid the cycle after the read edge.
REQ-011 SHALL have port BUSY, output, 1: high in every state except IDLE and DONE.
REQ-012 SHALL have port DONE, output, 1: one-cycle pulse marking end of test.
REQ-013 SHALL have port PASS, output, 1: test result, held until next accepted START.
REQ-014 SHALL have port ERR_CNT, output, AW+1: mismatch count, saturating at all-ones.
REQ-015 SHALL have port ERR_ADDR, output, AW: address of the first mismatch.

Function
REQ-016 SHALL implement the FSM IDLE -> WR_PASS -> RD_PASS -> FLUSH -> DONE -> IDLE.
REQ-017 SHALL define pat(a,inv) = a zero-extended or truncated to DW bits, XOR all-ones when inv=1.
REQ-018 SHALL, on START=1 in IDLE: enter WR_PASS with A=0, EN=1, WR=1, D=pat(0,0), inv=0; clear ERR_CNT, ERR_ADDR and PASS.
REQ-019 SHALL, in WR_PASS, advance A by 1 each cycle with D=pat(A,inv); after A=2^AW-1 enter RD_PASS with A=0, EN=1, WR=0.
REQ-020 SHALL, in RD_PASS, advance A by 1 each cycle; after A=2^AW-1 enter FLUSH with EN=0.
REQ-021 SHALL register the address of each issued read and compare Q against pat(that address,inv) one cycle later, covering all reads including the last, which is compared in FLUSH.
REQ-022 SHALL, on mismatch, increment ERR_CNT (saturating), and load ERR_ADDR only when ERR_CNT was 0.
REQ-023 SHALL, from FLUSH, enter DONE, or re-enter WR_PASS with inv=1 per REQ-031.
REQ-024 SHALL, in DONE, assert DONE for exactly one cycle, set PASS = (ERR_CNT==0), then return to IDLE.
REQ-025 SHALL keep EN=0 in IDLE, FLUSH and DONE, and SHALL never assert EN with WR changing mid-access.
REQ-026 SHALL ignore START while not in IDLE; START held high re-triggers from IDLE on the cycle after DONE.
REQ-027 SHALL take 2^(AW+1)+1 cycles per pass from the START edge to the DONE-state edge (9 for defaults).

Reset
REQ-028 SHALL, on RST=1 at any time, immediately force state IDLE, A=0, D=0, EN=0, WR=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, ERR_ADDR=0, inv=0.
REQ-029 SHALL, on RST mid-test, abandon the test with no DONE pulse and restart only on a new START after release.

Configuration
REQ-030 SHALL use macro RAM_BIST_INV_PASS_EN.
REQ-031 SHALL, with the macro defined, run a second write/read pass with inv=1 after the first FLUSH, accumulating errors across both passes; total is 2*(2^(AW+1)+1) cycles.
REQ-032 SHALL, without the macro, run the single inv=0 pass only and contain no inv logic.

Verification
REQ-033 SHALL cover: defaults, fault-free RAM, START pulse -> writes 0,1,2,3 to addr 0..3, DONE 9 cycles after START edge, PASS=1, ERR_CNT=0.
REQ-034 SHALL cover: RAM model with addr 2 bit0 stuck-at-1 -> ERR_CNT=1, ERR_ADDR=2, PASS=0.
REQ-035 SHALL cover: Q forced to 0 on all reads -> ERR_CNT=3, ERR_ADDR=1 (addr 0 matches), PASS=0.
REQ-036 SHALL cover: RST pulsed during RD_PASS at A=1 -> all outputs zero asynchronously, no DONE; next START completes with PASS=1.
REQ-037 SHALL cover: START held high for 30 cycles -> back-to-back tests, DONE pulses spaced 11 cycles apart, START ignored while BUSY.
REQ-038 SHALL cover: RAM_BIST_INV_PASS_EN defined, bit0 stuck-at-0 at addr 1 -> inverted pass writes 7,6,5,4, DONE at cycle 18, ERR_CNT=1, ERR_ADDR=1.

Source files
------------

// File: rtl/ram_bist_ctrl.sv
// ---------------------------------------------------------------------------
// ram_bist_ctrl -- March-style built-in self test controller for a
// single-port synchronous RAM.
//
// A test writes pat(a) to every address, then reads every address back.
// Each read word is compared against its expected pattern on the following
// cycle. Mismatches are counted, and the address of the first mismatch is
// kept.
//
// Optional feature (macro RAM_BIST_INV_PASS_EN):
//   When the macro is defined, a second write/read pass runs with the
//   inverted pattern. Errors accumulate across both passes.
//   When the macro is undefined, only the true-pattern pass runs.
//
// Parameters:
//   AW        RAM address width (depth 2^AW words)
//   DW        RAM data width
// Ports:
//   CLK       clock, rising edge
//   RST       asynchronous active-high reset
//   START     test request, sampled only in IDLE
//   A, D      registered RAM address / write data
//   EN, WR    registered RAM enable / write strobe (WR=0 means read)
//   Q         RAM read data, valid the cycle after the read edge
//   BUSY      high while a test is running (not IDLE, not DONE)
//   DONE      one-cycle end-of-test pulse
//   PASS      result of the last test, held until the next START
//   ERR_CNT   saturating mismatch count
//   ERR_ADDR  address of the first mismatch
// ---------------------------------------------------------------------------
module ram_bist_ctrl #(
    parameter int AW = 2,
    parameter int DW = 3
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    output logic [AW-1:0] A,
    output logic [DW-1:0] D,
    output logic          EN,
    output logic          WR,
    input  logic [DW-1:0] Q,
    output logic          BUSY,
    output logic          DONE,
    output logic          PASS,
    output logic [AW:0]   ERR_CNT,
    output logic [AW-1:0] ERR_ADDR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_PASS,
        S_RD_PASS,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_a;
    logic [AW-1:0] w_a_nxt;
    logic [DW-1:0] r_d;
    logic [DW-1:0] w_d_nxt;
    logic          r_en;
    logic          w_en_nxt;
    logic          r_wr;
    logic          w_wr_nxt;
    logic          r_pass;
    logic          w_pass_nxt;
    logic [AW:0]   r_err_cnt;
    logic [AW:0]   w_err_cnt_nxt;
    logic [AW-1:0] r_err_addr;
    logic [AW-1:0] w_err_addr_nxt;
    logic          r_rd_vld;     // a read was issued on the previous edge
    logic [AW-1:0] r_rd_addr;    // address of that read
    logic          w_start_acc;
    logic          w_last_addr;
    logic          w_mismatch;
    logic [DW-1:0] w_exp;
`ifdef RAM_BIST_INV_PASS_EN
    logic          r_inv;
    logic          w_inv_nxt;
`endif

    // Address zero-extended or truncated to the data width.
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        pat = DW'(a);
    endfunction

    assign w_start_acc = (r_state == S_IDLE) && START;
    assign w_last_addr = (r_a == {AW{1'b1}});

`ifdef RAM_BIST_INV_PASS_EN
    assign w_d_nxt = pat(w_a_nxt) ^ {DW{w_inv_nxt}};
    // r_inv is still the pass that issued the read, even on the FLUSH edge.
    assign w_exp   = pat(r_rd_addr) ^ {DW{r_inv}};
`else
    assign w_d_nxt = pat(w_a_nxt);
    assign w_exp   = pat(r_rd_addr);
`endif

    assign w_mismatch = r_rd_vld && (Q != w_exp);

    // NOTE: every always_comb output is given a default first so that no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = '0;
        w_en_nxt    = 1'b0;
        w_wr_nxt    = 1'b0;
`ifdef RAM_BIST_INV_PASS_EN
        w_inv_nxt   = r_inv;
`endif
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_nxt = S_WR_PASS;
                    w_en_nxt    = 1'b1;
                    w_wr_nxt    = 1'b1;
`ifdef RAM_BIST_INV_PASS_EN
                    w_inv_nxt   = 1'b0;
`endif
                end
            end
            S_WR_PASS: begin
                w_en_nxt = 1'b1;
                if (w_last_addr) begin
                    w_state_nxt = S_RD_PASS;
                end else begin
                    w_a_nxt  = r_a + AW'(1);
                    w_wr_nxt = 1'b1;
                end
            end
            S_RD_PASS: begin
                if (w_last_addr) begin
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_a_nxt  = r_a + AW'(1);
                    w_en_nxt = 1'b1;
                end
            end
            S_FLUSH: begin
`ifdef RAM_BIST_INV_PASS_EN
                if (!r_inv) begin
                    w_state_nxt = S_WR_PASS;
                    w_en_nxt    = 1'b1;
                    w_wr_nxt    = 1'b1;
                    w_inv_nxt   = 1'b1;
                end else begin
                    w_state_nxt = S_DONE;
                end
`else
                w_state_nxt = S_DONE;
`endif
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Error bookkeeping. A new START clears the result of the previous test.
    always_comb begin
        w_err_cnt_nxt  = r_err_cnt;
        w_err_addr_nxt = r_err_addr;
        w_pass_nxt     = r_pass;
        if (w_start_acc) begin
            w_err_cnt_nxt  = '0;
            w_err_addr_nxt = '0;
            w_pass_nxt     = 1'b0;
        end else begin
            if (w_mismatch) begin
                if (r_err_cnt != {(AW+1){1'b1}}) begin
                    w_err_cnt_nxt = r_err_cnt + (AW+1)'(1);
                end
                if (r_err_cnt == '0) begin
                    w_err_addr_nxt = r_rd_addr;
                end
            end
            // Use the count that includes the final compare made on this edge.
            if ((r_state == S_FLUSH) && (w_state_nxt == S_DONE)) begin
                w_pass_nxt = (w_err_cnt_nxt == '0);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values of the others.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_d        <= '0;
            r_en       <= 1'b0;
            r_wr       <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= '0;
            r_err_addr <= '0;
            r_rd_vld   <= 1'b0;
            r_rd_addr  <= '0;
`ifdef RAM_BIST_INV_PASS_EN
            r_inv      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_a        <= w_a_nxt;
            r_d        <= w_d_nxt;
            r_en       <= w_en_nxt;
            r_wr       <= w_wr_nxt;
            r_pass     <= w_pass_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
            r_err_addr <= w_err_addr_nxt;
            r_rd_vld   <= r_en & ~r_wr;
            r_rd_addr  <= r_a;
`ifdef RAM_BIST_INV_PASS_EN
            r_inv      <= w_inv_nxt;
`endif
        end
    end

    assign A        = r_a;
    assign D        = r_d;
    assign EN       = r_en;
    assign WR       = r_wr;
    assign BUSY     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign DONE     = (r_state == S_DONE);
    assign PASS     = r_pass;
    assign ERR_CNT  = r_err_cnt;
    assign ERR_ADDR = r_err_addr;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_bist_ctrl -- directed self-checking bench for ram_bist_ctrl.
// The bench contains a behavioural RAM with selectable read faults.
// Expected values are hand-computed for AW=2 and DW=3.
// When RAM_BIST_INV_PASS_EN is defined, the constants for the two-pass
// variant are used instead.
// ---------------------------------------------------------------------------
module tb_ram_bist_ctrl;
    localparam int AW = 2;
    localparam int DW = 3;
`ifdef RAM_BIST_INV_PASS_EN
    localparam int N_CYC   = 18;  // START edge to DONE-state edge
    localparam int N_WR    = 8;   // writes per test
    localparam int GAP     = 20;  // DONE spacing with START held
    localparam int N_PULSE = 2;   // DONE pulses with START held for 30 edges
    localparam int QZ_ERR  = 7;   // Q stuck at 0: 3 + 4 errors, saturates at 7
`else
    localparam int N_CYC   = 9;
    localparam int N_WR    = 4;
    localparam int GAP     = 11;
    localparam int N_PULSE = 3;
    localparam int QZ_ERR  = 3;
`endif

    logic          CLK   = 1'b0;
    logic          RST   = 1'b0;
    logic          START = 1'b0;
    logic [AW-1:0] A;
    logic [DW-1:0] D;
    logic          EN;
    logic          WR;
    logic [DW-1:0] Q     = '0;
    logic          BUSY;
    logic          DONE;
    logic          PASS;
    logic [AW:0]   ERR_CNT;
    logic [AW-1:0] ERR_ADDR;

    logic [DW-1:0] mem [4];
    logic [DW-1:0] wr_log [$];
    logic [DW-1:0] exp_wr [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7, 3'd6, 3'd5, 3'd4};
    int            fault_mode = 0;  // 0 none, 1 a2.b0 SA1, 2 Q=0, 3 a1.b0 SA0
    int            n_checks   = 0;
    int            n_fail     = 0;
    int            cyc;

    ram_bist_ctrl #(.AW(AW), .DW(DW)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .A        (A),
        .D        (D),
        .EN       (EN),
        .WR       (WR),
        .Q        (Q),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .PASS     (PASS),
        .ERR_CNT  (ERR_CNT),
        .ERR_ADDR (ERR_ADDR)
    );

    always #5 CLK = ~CLK;

    // Synchronous single-port RAM with optional faults on the read path.
    always @(posedge CLK) begin
        if (EN && WR) begin
            mem[A] <= D;
            wr_log.push_back(D);
        end
        if (EN && !WR) begin
            case (fault_mode)
                1:       Q <= (A == 2'd2) ? (mem[A] | 3'b001) : mem[A];
                2:       Q <= '0;
                3:       Q <= (A == 2'd1) ? (mem[A] & 3'b110) : mem[A];
                default: Q <= mem[A];
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero();
        check("rst_A",        32'(A),        32'd0);
        check("rst_D",        32'(D),        32'd0);
        check("rst_EN",       32'(EN),       32'd0);
        check("rst_WR",       32'(WR),       32'd0);
        check("rst_BUSY",     32'(BUSY),     32'd0);
        check("rst_DONE",     32'(DONE),     32'd0);
        check("rst_PASS",     32'(PASS),     32'd0);
        check("rst_ERR_CNT",  32'(ERR_CNT),  32'd0);
        check("rst_ERR_ADDR", 32'(ERR_ADDR), 32'd0);
    endtask

    // Pulse START for one edge, then count edges until DONE appears.
    task automatic run_test(output int c);
        c = -1;
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        check("busy_after_start",  32'(BUSY),    32'd1);
        check("pass_cleared",      32'(PASS),    32'd0);
        check("errcnt_cleared",    32'(ERR_CNT), 32'd0);
        check("first_write",       32'({EN, WR, A, D}), 32'({1'b1, 1'b1, 2'd0, 3'd0}));
        for (int i = 1; i <= 100; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (DONE) begin
                c = i;
                break;
            end
        end
        check("done_latency", 32'(c), 32'(N_CYC));
        check("busy_in_done", 32'(BUSY), 32'd0);
        check("en_in_done",   32'(EN),   32'd0);
    endtask

    initial begin
        // Power-up reset, checked before any clock edge.
        #1 RST = 1'b1;
        #2;
        check_all_zero();
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // Fault-free RAM: the write sequence, the latency and PASS.
        fault_mode = 0;
        wr_log.delete();
        run_test(cyc);
        check("ok_pass",    32'(PASS),    32'd1);
        check("ok_errcnt",  32'(ERR_CNT), 32'd0);
        check("ok_nwrites", 32'(wr_log.size()), 32'(N_WR));
        for (int i = 0; i < N_WR; i++) begin
            if (i < wr_log.size()) check($sformatf("ok_wr%0d", i), 32'(wr_log[i]), 32'(exp_wr[i]));
        end
        repeat (3) @(negedge CLK);
        check("ok_pass_held", 32'(PASS), 32'd1);
        check("ok_done_low",  32'(DONE), 32'd0);
        check("ok_idle_en",   32'(EN),   32'd0);

        // Address 2, bit 0 stuck at 1.
        fault_mode = 1;
        run_test(cyc);
        check("sa1_errcnt",  32'(ERR_CNT),  32'd1);
        check("sa1_erraddr", 32'(ERR_ADDR), 32'd2);
        check("sa1_pass",    32'(PASS),     32'd0);

        // Q forced to 0: address 0 matches, and every later read fails.
        fault_mode = 2;
        run_test(cyc);
        check("qz_errcnt",  32'(ERR_CNT),  32'(QZ_ERR));
        check("qz_erraddr", 32'(ERR_ADDR), 32'd1);
        check("qz_pass",    32'(PASS),     32'd0);

        // Address 1, bit 0 stuck at 0: only the true-pattern read of 1 fails.
        fault_mode = 3;
        wr_log.delete();
        run_test(cyc);
        check("sa0_errcnt",  32'(ERR_CNT),  32'd1);
        check("sa0_erraddr", 32'(ERR_ADDR), 32'd1);
        check("sa0_pass",    32'(PASS),     32'd0);
        check("sa0_nwrites", 32'(wr_log.size()), 32'(N_WR));
        for (int i = 0; i < N_WR; i++) begin
            if (i < wr_log.size()) check($sformatf("sa0_wr%0d", i), 32'(wr_log[i]), 32'(exp_wr[i]));
        end

        // Reset during RD_PASS at A=1: abandon the test, with no DONE pulse.
        fault_mode = 0;
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        begin
            bit found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                if (EN && !WR && A == 2'd1) found = 1'b1;
                else @(negedge CLK);
            end
            check("mid_rd_reached", 32'(found), 32'd1);
        end
        #1 RST = 1'b1;
        #1;
        check_all_zero();
        @(negedge CLK);
        RST = 1'b0;
        begin
            int n_done = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge CLK);
                if (DONE) n_done++;
            end
            check("no_done_after_rst", 32'(n_done), 32'd0);
            check("idle_after_rst",    32'(BUSY),   32'd0);
        end
        run_test(cyc);
        check("rst_rerun_pass",   32'(PASS),    32'd1);
        check("rst_rerun_errcnt", 32'(ERR_CNT), 32'd0);

        // START held high for 30 edges gives back-to-back tests.
        begin
            int n_pulse = 0;
            int first   = -1;
            int prev    = -1;
            @(negedge CLK);
            START = 1'b1;
            for (int i = 0; i < 45; i++) begin
                @(posedge CLK);
                @(negedge CLK);
                if (i == 29) START = 1'b0;
                if (DONE) begin
                    if (n_pulse == 0) first = i;
                    else check("held_done_gap", 32'(i - prev), 32'(GAP));
                    prev = i;
                    n_pulse++;
                end
            end
            check("held_first_done", 32'(first),   32'(N_CYC));
            check("held_n_pulses",   32'(n_pulse), 32'(N_PULSE));
            check("held_idle_end",   32'(BUSY),    32'd0);
            check("held_pass",       32'(PASS),    32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
